// File: rtl/ctrl_mem.sv
// ctrl_mem: arbitrates byte writes, data reads and instruction reads onto one byte-wide RAM port.
// Latency: writes issue in the request cycle; an N-byte read completes with done in cycle N+2.
// Backpressure: per-requester wait outputs; a running read burst stalls every other requester.
module ctrl_mem #(
    parameter int          ADDR_W = 32,
    parameter logic [1:0]  IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    // data read
    input  logic              read_i,
    input  logic              sign_i,
    input  logic [2:0]        len_i,
    input  logic [ADDR_W-1:0] r_addr_i,
    output logic [31:0]       r_data_o,
    output logic              r_done_o,
    output logic              r_wait_o,
    // instruction read
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [31:0]       i_data_o,
    output logic              i_done_o,
    output logic              i_wait_o,
    // byte write
    input  logic              write_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [7:0]        w_data_i,
    output logic              w_wait_o,
    output logic              writting_o,
    // RAM
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, DREAD, IREAD} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;      // bytes received so far
    logic [2:0]          acnt_q, acnt_d;    // addresses issued so far
    logic [2:0]          n_q, n_d;          // burst length in bytes
    logic                sign_q, sign_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         asm_q, asm_d;      // little-endian assembly register
    logic [31:0]         data_q, data_d;
    logic                r_done_q, r_done_d;
    logic                i_done_q, i_done_d;

    logic                idle;
    logic                wr_go;
    logic                rd_go;
    logic                ird_go;
    logic [4:0]          byte_pos;
    logic [31:0]         ext_v;

    // Request arbitration: write beats data read beats instruction read, only while idle
    always_comb begin
        idle     = (state_q == IDLE);
        w_wait_o = !idle || ((w_addr_i[17:16] == IO_SEL) && io_buffer_full);
        r_wait_o = !idle || write_i;
        i_wait_o = !idle || write_i || read_i;
        wr_go    = write_i && !w_wait_o && !rst;
        rd_go    = read_i && !r_wait_o;
        ird_go   = i_read_i && !i_wait_o;
    end

    // Next-state: latch the request on acceptance, then issue addresses and collect bytes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acnt_d   = acnt_q;
        n_d      = n_q;
        sign_d   = sign_q;
        base_d   = base_q;
        asm_d    = asm_q;
        data_d   = 32'd0;
        r_done_d = 1'b0;
        i_done_d = 1'b0;
        byte_pos = {cnt_q[1:0], 3'b000};
        ext_v    = 32'd0;
        case (state_q)
            IDLE: begin
                if (rd_go) begin
                    state_d = DREAD;
                    base_d  = r_addr_i;
                    sign_d  = sign_i;
                    cnt_d   = 3'd0;
                    acnt_d  = 3'd0;
                    asm_d   = 32'd0;
                    case (len_i)
                        3'd1:    n_d = 3'd1;
                        3'd2:    n_d = 3'd2;
                        default: n_d = 3'd4;
                    endcase
                end else if (ird_go) begin
                    state_d = IREAD;
                    base_d  = i_addr_i;
                    sign_d  = 1'b0;
                    cnt_d   = 3'd0;
                    acnt_d  = 3'd0;
                    asm_d   = 32'd0;
                    n_d     = 3'd4;
                end
            end
            default: begin
                if (r_done_q || i_done_q) begin
                    // done cycle: result is on the outputs, go back to idle
                    state_d = IDLE;
                end else begin
                    if (acnt_q < n_q) begin
                        acnt_d = acnt_q + 3'd1;
                    end
                    // a byte requested last cycle is on mem_din now
                    if (acnt_q != cnt_q) begin
                        asm_d[byte_pos +: 8] = mem_din;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q + 3'd1 == n_q) begin
                            case (n_q)
                                3'd1:    ext_v = sign_q ? {{24{asm_d[7]}}, asm_d[7:0]}
                                                        : {24'd0, asm_d[7:0]};
                                3'd2:    ext_v = sign_q ? {{16{asm_d[15]}}, asm_d[15:0]}
                                                        : {16'd0, asm_d[15:0]};
                                default: ext_v = asm_d;
                            endcase
                            data_d   = ext_v;
                            r_done_d = (state_q == DREAD);
                            i_done_d = (state_q == IREAD);
                        end
                    end
                end
            end
        endcase
    end

    // State registers, cleared asynchronously so a reset mid-burst drops the read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            acnt_q   <= 3'd0;
            n_q      <= 3'd0;
            sign_q   <= 1'b0;
            base_q   <= '0;
            asm_q    <= 32'd0;
            data_q   <= 32'd0;
            r_done_q <= 1'b0;
            i_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acnt_q   <= acnt_d;
            n_q      <= n_d;
            sign_q   <= sign_d;
            base_q   <= base_d;
            asm_q    <= asm_d;
            data_q   <= data_d;
            r_done_q <= r_done_d;
            i_done_q <= i_done_d;
        end
    end

    // RAM port mux: write passes straight through, burst addresses come from the latched base
    always_comb begin
        mem_a      = '0;
        mem_dout   = 8'd0;
        mem_wr     = 1'b0;
        writting_o = 1'b0;
        if (wr_go) begin
            mem_a      = w_addr_i;
            mem_dout   = w_data_i;
            mem_wr     = 1'b1;
            writting_o = 1'b1;
        end else if (!idle && !r_done_q && !i_done_q && (acnt_q < n_q)) begin
            mem_a = base_q + ADDR_W'(acnt_q);
        end
    end

    // Result ports carry data only during their done pulse
    always_comb begin
        r_done_o = r_done_q;
        i_done_o = i_done_q;
        r_data_o = r_done_q ? data_q : 32'd0;
        i_data_o = i_done_q ? data_q : 32'd0;
    end

endmodule

// File: tb/tb_ctrl_mem.sv
// Random + directed bench for ctrl_mem: a driver predicts acceptance and results from a
// byte-array reference memory; a negedge monitor pops expectations as the DUT presents them.
module tb_ctrl_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_i = 0, sign_i = 0, i_read_i = 0, write_i = 0, io_buffer_full = 0;
    logic [2:0]  len_i = 0;
    logic [31:0] r_addr_i = 0, i_addr_i = 0, w_addr_i = 0;
    logic [7:0]  w_data_i = 0;
    logic [7:0]  mem_din = 0;
    logic [31:0] r_data_o, i_data_o, mem_a;
    logic        r_done_o, r_wait_o, i_done_o, i_wait_o, w_wait_o, writting_o, mem_wr;
    logic [7:0]  mem_dout;

    ctrl_mem #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst),
        .read_i(read_i), .sign_i(sign_i), .len_i(len_i), .r_addr_i(r_addr_i),
        .r_data_o(r_data_o), .r_done_o(r_done_o), .r_wait_o(r_wait_o),
        .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_data_o(i_data_o),
        .i_done_o(i_done_o), .i_wait_o(i_wait_o),
        .write_i(write_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .w_wait_o(w_wait_o), .writting_o(writting_o),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct { bit instr; logic [31:0] data; int cyc; } rsp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    rsp_t        rq[$];
    wr_t         exp_w[int];
    logic [31:0] exp_a[int];
    logic [7:0]  phys[logic [31:0]];
    logic [7:0]  refm[logic [31:0]];
    int          busy_end = -1;

    function automatic logic [7:0] init_b(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_b(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // RAM with one-cycle read latency; writes land on the clock edge
    always @(posedge clk) begin
        if (mem_wr) phys[mem_a] = mem_dout;
        mem_din <= phys.exists(mem_a) ? phys[mem_a] : init_b(mem_a);
    end

    // Reference: record issued addresses and the expected result of an accepted read
    task automatic accept(input bit instr, input logic [31:0] base, input int n,
                          input bit s, input int c);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = base + k;
            exp_a[c + 1 + k] = a;
            v = v | (32'(ref_rd(a)) << (8 * k));
        end
        if (s && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (s && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        rq.push_back('{instr: instr, data: v, cyc: c + n + 2});
        busy_end = c + n + 2;
    endtask

    // One cycle of stimulus plus the expected acceptance and wait outputs
    task automatic step(input logic w, input logic [31:0] wa, input logic [7:0] wd,
                        input logic r, input logic s, input logic [2:0] ln,
                        input logic [31:0] ra, input logic ir, input logic [31:0] ia,
                        input logic f);
        int c;
        bit idle, wio;
        @(posedge clk); #1;
        write_i = w; w_addr_i = wa; w_data_i = wd;
        read_i = r; sign_i = s; len_i = ln; r_addr_i = ra;
        i_read_i = ir; i_addr_i = ia; io_buffer_full = f;
        c    = cyc;
        idle = (c > busy_end);
        wio  = (wa[17:16] == 2'b11) && f;
        if (idle) begin
            if (w && !wio) begin
                exp_w[c] = '{a: wa, d: wd};
                refm[wa] = wd;
            end else if (!w && r) begin
                accept(1'b0, ra, (ln == 3'd1) ? 1 : (ln == 3'd2) ? 2 : 4, s, c);
            end else if (!w && !r && ir) begin
                accept(1'b1, ia, 4, 1'b0, c);
            end
        end
        @(negedge clk);
        chk("w_wait", w_wait_o, !idle || wio);
        chk("r_wait", r_wait_o, !idle || w);
        chk("i_wait", i_wait_o, !idle || w || r);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preset(input logic [31:0] a, input logic [7:0] d);
        phys[a] = d;
        refm[a] = d;
    endtask

    // Monitor: RAM port activity and done pulses against the expectations
    always @(negedge clk) begin
        rsp_t e;
        if (!rst) begin
            if (exp_w.exists(cyc)) begin
                chk("wr_mem_wr", mem_wr, 1);
                chk("wr_writting", writting_o, 1);
                chk("wr_addr", mem_a, exp_w[cyc].a);
                chk("wr_data", mem_dout, exp_w[cyc].d);
                exp_w.delete(cyc);
            end else if (exp_a.exists(cyc)) begin
                chk("rd_addr", mem_a, exp_a[cyc]);
                chk("rd_mem_wr", mem_wr, 0);
                chk("rd_writting", writting_o, 0);
                exp_a.delete(cyc);
            end else begin
                chk("quiet_addr", mem_a, 0);
                chk("quiet_wr", mem_wr, 0);
                chk("quiet_dout", mem_dout, 0);
                chk("quiet_writting", writting_o, 0);
            end
            if (rq.size() > 0 && rq[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL done_missing cyc=%0d got=none exp=done_at_%0d", cyc, rq[0].cyc);
                void'(rq.pop_front());
            end
            if (r_done_o || i_done_o) begin
                if (rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_done cyc=%0d got=r%0d_i%0d exp=none", cyc, r_done_o, i_done_o);
                end else begin
                    e = rq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("r_done", r_done_o, !e.instr);
                    chk("i_done", i_done_o, e.instr);
                    if (e.instr) chk("i_data", i_data_o, e.data);
                    else         chk("r_data", r_data_o, e.data);
                end
            end else begin
                chk("r_data_idle", r_data_o, 0);
                chk("i_data_idle", i_data_o, 0);
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_r_done", r_done_o, 0);
        chk("rst_i_done", i_done_o, 0);
        chk("rst_r_data", r_data_o, 0);
        chk("rst_i_data", i_data_o, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
    endtask

    initial begin
        logic [31:0] ra, wa;
        int wait_cnt;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;

        // 4-byte data read at 0x100
        preset(32'h100, 8'h11); preset(32'h101, 8'h22);
        preset(32'h102, 8'h33); preset(32'h103, 8'h44);
        step(0, 0, 0, 1, 0, 3'd4, 32'h100, 0, 0, 0);
        idle_n(7);

        // byte reads with and without sign extension, then halfword
        preset(32'h20, 8'h80); preset(32'h21, 8'hC3);
        step(0, 0, 0, 1, 1, 3'd1, 32'h20, 0, 0, 0);
        idle_n(4);
        step(0, 0, 0, 1, 0, 3'd1, 32'h20, 0, 0, 0);
        idle_n(4);
        step(0, 0, 0, 1, 1, 3'd2, 32'h20, 0, 0, 0);
        idle_n(5);
        step(0, 0, 0, 1, 1, 3'd7, 32'h20, 0, 0, 0);  // odd length behaves as 4
        idle_n(7);

        // write, data read and instruction read together
        step(1, 32'h40, 8'hA5, 1, 0, 3'd1, 32'h40, 1, 32'h80, 0);
        step(0, 0, 0, 1, 0, 3'd1, 32'h40, 1, 32'h80, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0);
        idle_n(6);

        // I/O write held off by a full buffer, issued when it drains
        step(1, 32'h0003_0000, 8'h5C, 0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h0003_0000, 8'h5C, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 3'd1, 32'h0003_0000, 0, 0, 0);
        idle_n(4);

        // instruction read wrapping the top of the address space
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0);
        idle_n(7);

        // reset in the third burst cycle of a 4-byte read
        step(0, 0, 0, 1, 0, 3'd4, 32'h100, 0, 0, 0);
        idle_n(2);
        @(posedge clk); #1;
        rst = 1'b1;
        rq.delete(); exp_a.delete(); exp_w.delete();
        busy_end = -1;
        #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 0, 0, 1, 0, 3'd4, 32'h100, 0, 0, 0);
        idle_n(7);

        // randomized traffic over a small window so writes are read back
        for (int i = 0; i < 800; i++) begin
            ra = ($urandom_range(1) ? 32'h0003_0000 : 32'h0) | 32'($urandom_range(63));
            wa = ($urandom_range(1) ? 32'h0003_0000 : 32'h0) | 32'($urandom_range(63));
            if ($urandom_range(7) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(3));
            step($urandom_range(3) == 0, wa, 8'($urandom),
                 $urandom_range(9) < 3, 1'($urandom), 3'($urandom_range(7)), ra,
                 $urandom_range(9) < 3, ra ^ 32'h10, $urandom_range(9) < 3);
        end

        // drain outstanding reads
        wait_cnt = 0;
        while (rq.size() > 0 && wait_cnt < 20) begin
            idle_n(1);
            wait_cnt++;
        end
        if (rq.size() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout cyc=%0d got=%0d_pending exp=0", cyc, rq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_mem.md
CTRL_MEM -- requirements
Module: ctrl_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter IO_SEL, default 2'b11, value of addr[17:16] that marks an I/O address.
REQ-003 SHALL have ports: clk  in  1  single clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have data-read ports: read_i in 1; sign_i in 1; len_i in 3 (1/2/4 bytes); r_addr_i in ADDR_W; r_data_o out 32; r_done_o out 1; r_wait_o out 1.
REQ-005 SHALL have instruction-read ports: i_read_i in 1; i_addr_i in ADDR_W; i_data_o out 32; i_done_o out 1; i_wait_o out 1.
REQ-006 SHALL have byte-write ports: write_i in 1; w_addr_i in ADDR_W; w_data_i in 8; w_wait_o out 1; writting_o out 1 (byte accepted this cycle).
REQ-007 SHALL have RAM ports: mem_din in 8 (read byte); mem_dout out 8; mem_a out ADDR_W; mem_wr out 1 (1 = write); io_buffer_full in 1.

Function
REQ-008 SHALL implement FSM states IDLE, DREAD, IREAD; a byte counter cnt (0..4); a 32-bit assembly register.
REQ-009 In IDLE, SHALL accept a byte write combinationally: write_i && !w_wait_o drives mem_a=w_addr_i, mem_dout=w_data_i, mem_wr=1, writting_o=1 in that same cycle.
REQ-010 w_wait_o SHALL be 1 when state!=IDLE, or when w_addr_i[17:16]==IO_SEL and io_buffer_full=1; else 0.
REQ-011 r_wait_o SHALL be 1 when state!=IDLE or write_i=1; i_wait_o SHALL be 1 when state!=IDLE, write_i=1 or read_i=1.
REQ-012 Priority in IDLE: write > data read > instruction read; an accepted read burst is never preempted.
REQ-013 A read is accepted at the clock edge ending cycle 0 in which its request is high and its wait low; address, len, sign are latched then.
REQ-014 Burst of N bytes: mem_a=base+k, mem_wr=0 in cycle 1+k (k=0..N-1); byte k is sampled from mem_din at the end of cycle 2+k (one-cycle RAM latency).
REQ-015 Bytes SHALL be placed little-endian: byte k into bits [8k+7:8k].
REQ-016 Data read N = len_i; len_i values other than 1, 2, 4 SHALL be treated as 4; instruction read N = 4 always.
REQ-017 sign_i=1: N=1 extends bit 7, N=2 extends bit 15 into upper bits; sign_i=0 zero-extends; ignored for N=4.
REQ-018 r_done_o (or i_done_o) SHALL pulse high for exactly one cycle, cycle N+2, with r_data_o (i_data_o) valid in that cycle; FSM returns to IDLE in the same cycle.
REQ-019 r_data_o/i_data_o SHALL be 0 whenever the corresponding done is 0.
REQ-020 A new request may be accepted in the done cycle only if its wait is low (it is not: state leaves burst at end of done cycle); earliest back-to-back acceptance is cycle N+3.
REQ-021 When no access is active: mem_a=0, mem_dout=0, mem_wr=0, writting_o=0.
REQ-022 Address increment SHALL wrap modulo 2^ADDR_W.
REQ-023 Request inputs changing after acceptance SHALL not affect the burst in progress.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, cnt=0, assembly register=0, all done outputs 0, data outputs 0, mem_wr=0, mem_a=0, mem_dout=0.
REQ-025 Reset mid-burst SHALL discard the partial read with no done pulse; after release the block accepts requests from cycle 0 normally.

Verification
REQ-026 Data read len 4, addr 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 cycles 1-4, r_done_o=1 cycle 6, r_data_o=0x44332211.
REQ-027 Data read len 1, sign 1, byte 0x80 at 0x20 -> r_data_o=0xFFFFFF80 cycle 3; with sign 0 -> 0x00000080.
REQ-028 write_i, read_i, i_read_i all high in IDLE -> write accepted (mem_wr=1, writting_o=1), r_wait_o=1, i_wait_o=1; next cycle data read accepted before instruction read.
REQ-029 Write to 0x30000 with io_buffer_full=1 -> w_wait_o=1, mem_wr=0, writting_o=0; io_buffer_full drop -> write issued that cycle.
REQ-030 Instruction read at 0xFFFFFFFE -> mem_a FFFFFFFE, FFFFFFFF, 0, 1; i_done_o cycle 6.
REQ-031 rst asserted in cycle 3 of a 4-byte read -> no r_done_o, outputs 0 immediately; new read after release completes normally.
